// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with whole-line refill.
// Read hits answer combinationally in the request cycle; writes always go to memory.
module dcache_dm #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic                  cache_rd,
  input  logic                  cache_wr,
  input  logic [DATA_WIDTH-1:0] cache_wr_data,
  output logic [DATA_WIDTH-1:0] cache_data,
  output logic                  cache_waitrequest,
  input  logic                  cache_flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_waitrequest
);

  localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORDS     = 1 << OFFSET_BITS;
  localparam int WORD_BITS = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0]  data_arr [LINES*WORDS];
  logic [TAG_BITS-1:0]    tag_arr  [LINES];
  logic [LINES-1:0]       valid;

  logic [WORD_BITS-1:0]   lat_word;
  logic [DATA_WIDTH-1:0]  lat_data;
  logic [OFFSET_BITS-1:0] refill_cnt;
  logic                   flush_pending;

  logic [TAG_BITS-1:0]    req_tag, lat_tag;
  logic [INDEX_BITS-1:0]  req_index, lat_index;
  logic [OFFSET_BITS-1:0] req_offset, lat_offset;
  logic                   req_hit, lat_hit, refill_last, mem_ready;
  logic                   unused_addr_bits;

  assign req_tag    = cache_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_index  = cache_addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign req_offset = cache_addr[2 +: OFFSET_BITS];
  assign lat_tag    = lat_word[WORD_BITS-1 -: TAG_BITS];
  assign lat_index  = lat_word[OFFSET_BITS +: INDEX_BITS];
  assign lat_offset = lat_word[OFFSET_BITS-1:0];
  assign unused_addr_bits = ^cache_addr[1:0];

  assign req_hit     = valid[req_index] && (tag_arr[req_index] == req_tag);
  assign lat_hit     = valid[lat_index] && (tag_arr[lat_index] == lat_tag);
  assign refill_last = &refill_cnt;
  assign mem_ready   = !mem_waitrequest;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // A write wins over a simultaneous read; only a read miss starts a refill.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cache_wr)                 next_state = WRITE;
        else if (cache_rd && !req_hit) next_state = REFILL;
      end
      REFILL: if (mem_ready && refill_last) next_state = IDLE;
      WRITE:  if (mem_ready)                next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cache_waitrequest = 1'b0;
    cache_data        = '0;
    mem_rd            = 1'b0;
    mem_wr            = 1'b0;
    mem_addr          = '0;
    mem_wr_data       = '0;
    case (state)
      IDLE: begin
        if (cache_wr) begin
          cache_waitrequest = 1'b1;
        end else if (cache_rd) begin
          if (req_hit) cache_data = data_arr[{req_index, req_offset}];
          else         cache_waitrequest = 1'b1;
        end
      end
      REFILL: begin
        cache_waitrequest = 1'b1;
        mem_rd            = 1'b1;
        mem_addr          = {lat_tag, lat_index, refill_cnt, 2'b00};
      end
      WRITE: begin
        cache_waitrequest = mem_waitrequest;
        mem_wr            = 1'b1;
        mem_addr          = {lat_word, 2'b00};
        mem_wr_data       = lat_data;
      end
      default: cache_waitrequest = 1'b0;
    endcase
  end

  // Flushes seen while busy are deferred to the next IDLE cycle, where the
  // lookup of that cycle still sees the pre-flush valid bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid         <= '0;
      refill_cnt    <= '0;
      flush_pending <= 1'b0;
      lat_word      <= '0;
      lat_data      <= '0;
    end else begin
      if (state == IDLE) begin
        flush_pending <= 1'b0;
        if (cache_flush || flush_pending) valid <= '0;
        if (cache_wr) begin
          lat_word <= cache_addr[ADDR_WIDTH-1:2];
          lat_data <= cache_wr_data;
        end else if (cache_rd && !req_hit) begin
          lat_word   <= cache_addr[ADDR_WIDTH-1:2];
          refill_cnt <= '0;
        end
      end else if (cache_flush) begin
        flush_pending <= 1'b1;
      end
      if (state == REFILL && mem_ready) begin
        refill_cnt <= refill_cnt + 1'b1;
        if (refill_last) valid[lat_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == REFILL && mem_ready) begin
      data_arr[{lat_index, refill_cnt}] <= mem_data;
      if (refill_last) tag_arr[lat_index] <= lat_tag;
    end
    if (state == WRITE && mem_ready && lat_hit)
      data_arr[{lat_index, lat_offset}] <= lat_data;
  end

endmodule
